nn_sequencer: RTL and testbench

Control FSM that sequences the shared single-lane MAC datapath of the neural network: hidden layer (N_IN→N_HID), then output layer (N_HID→N_OUT), over every test sample.
- Generates feature, weight and hidden-buffer addresses, plus MAC clear and enable.
- Performs argmax over the output scores.
- Reports one class index per sample: `result` is valid with a `batch_done` pulse; `done` rises after the last sample.

---
 rtl/nn_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_nn_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nn_sequencer : MAC-datapath sequencer (hidden layer, output layer, argmax).
// Optional per-neuron bias term enabled by defining NN_SEQ_BIAS_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module nn_sequencer #(
    parameter int N_SAMPLES = 750,
    parameter int N_IN      = 62,
    parameter int N_HID     = 30,
    parameter int N_OUT     = 10,
    parameter int SAMP_W    = 10,
    parameter int FEAT_W    = 8,
    parameter int WADDR_W   = 12,
    parameter int ACC_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [SAMP_W-1:0]  sample_idx,
    output logic [FEAT_W-1:0]  feat_idx,
    output logic [WADDR_W-1:0] w_addr,
    output logic               layer_sel,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               hid_we,
    output logic [FEAT_W-1:0]  hid_waddr,
    input  logic [ACC_W-1:0]   acc_in,
    output logic [7:0]         result,
    output logic               batch_done,
    output logic               done
);

`ifdef NN_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    localparam logic [FEAT_W-1:0] L1_LAST   = FEAT_W'(N_IN - 1 + BIAS);
    localparam logic [FEAT_W-1:0] L2_LAST   = FEAT_W'(N_HID - 1 + BIAS);
    localparam logic [FEAT_W-1:0] HID_LAST  = FEAT_W'(N_HID - 1);
    localparam logic [FEAT_W-1:0] OUT_LAST  = FEAT_W'(N_OUT - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(N_SAMPLES - 1);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        L1_RUN     = 4'd1,
        L1_DRAIN   = 4'd2,
        L1_WB      = 4'd3,
        L2_RUN     = 4'd4,
        L2_DRAIN   = 4'd5,
        L2_WB      = 4'd6,
        SAMPLE_END = 4'd7,
        DONE       = 4'd8
    } state_t;

    state_t                  state;
    logic [FEAT_W-1:0]       j;
    logic signed [ACC_W-1:0] best_val;
    logic [7:0]              best_idx;

    // Address/control outputs are registered so they hold the value that
    // belongs to the state being entered; weight rows are laid out back to
    // back, so w_addr simply advances by one per issued term within a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            j          <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            sample_idx <= '0;
            feat_idx   <= '0;
            w_addr     <= '0;
            layer_sel  <= 1'b0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            hid_we     <= 1'b0;
            hid_waddr  <= '0;
            result     <= '0;
            batch_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            mac_clr    <= 1'b0;
            hid_we     <= 1'b0;
            batch_done <= 1'b0;
            mac_en     <= (state == L1_RUN) || (state == L2_RUN);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= L1_RUN;
                        sample_idx <= '0;
                        j          <= '0;
                        feat_idx   <= '0;
                        w_addr     <= '0;
                        layer_sel  <= 1'b0;
                        mac_clr    <= 1'b1;
                        done       <= 1'b0;
                    end
                end

                L1_RUN: begin
                    if (feat_idx == L1_LAST) begin
                        state <= L1_DRAIN;
                    end else begin
                        feat_idx <= feat_idx + FEAT_W'(1);
                        w_addr   <= w_addr + WADDR_W'(1);
                    end
                end

                L1_DRAIN: begin
                    state     <= L1_WB;
                    hid_we    <= 1'b1;
                    hid_waddr <= j;
                end

                L1_WB: begin
                    state    <= (j == HID_LAST) ? L2_RUN : L1_RUN;
                    j        <= (j == HID_LAST) ? '0 : j + FEAT_W'(1);
                    layer_sel <= (j == HID_LAST);
                    feat_idx <= '0;
                    w_addr   <= w_addr + WADDR_W'(1);
                    mac_clr  <= 1'b1;
                end

                L2_RUN: begin
                    if (feat_idx == L2_LAST) begin
                        state <= L2_DRAIN;
                    end else begin
                        feat_idx <= feat_idx + FEAT_W'(1);
                        w_addr   <= w_addr + WADDR_W'(1);
                    end
                end

                L2_DRAIN: begin
                    state <= L2_WB;
                end

                L2_WB: begin
                    // Strict compare keeps the lowest index on ties.
                    if ((j == '0) || ($signed(acc_in) > best_val)) begin
                        best_val <= $signed(acc_in);
                        best_idx <= 8'(j);
                    end
                    if (j == OUT_LAST) begin
                        state <= SAMPLE_END;
                    end else begin
                        state    <= L2_RUN;
                        j        <= j + FEAT_W'(1);
                        feat_idx <= '0;
                        w_addr   <= w_addr + WADDR_W'(1);
                        mac_clr  <= 1'b1;
                    end
                end

                SAMPLE_END: begin
                    result     <= best_idx;
                    batch_done <= 1'b1;
                    if (sample_idx == SAMP_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= L1_RUN;
                        sample_idx <= sample_idx + SAMP_W'(1);
                        j          <= '0;
                        feat_idx   <= '0;
                        w_addr     <= '0;
                        layer_sel  <= 1'b0;
                        mac_clr    <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
// tb_nn_sequencer : scoreboard bench for nn_sequencer at reduced dimensions.
module tb_nn_sequencer;
    localparam int NS = 4, NI = 3, NH = 2, NO = 5;
    localparam int SW = 10, FW = 8, WW = 12, AW = 16;
`ifdef NN_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int W1    = NI + BIAS;
    localparam int W2    = NH + BIAS;
    localparam int R1    = W1 + 2;
    localparam int R2    = W2 + 2;
    localparam int CPS   = NH * R1 + NO * R2 + 1;
    localparam int BASE2 = NH * W1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] acc_in = '0;
    logic [SW-1:0] sample_idx;
    logic [FW-1:0] feat_idx;
    logic [WW-1:0] w_addr;
    logic          layer_sel, mac_clr, mac_en, hid_we, batch_done, done;
    logic [FW-1:0] hid_waddr;
    logic [7:0]    result;

    nn_sequencer #(
        .N_SAMPLES(NS), .N_IN(NI), .N_HID(NH), .N_OUT(NO),
        .SAMP_W(SW), .FEAT_W(FW), .WADDR_W(WW), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .sample_idx(sample_idx), .feat_idx(feat_idx), .w_addr(w_addr),
        .layer_sel(layer_sel), .mac_clr(mac_clr), .mac_en(mac_en),
        .hid_we(hid_we), .hid_waddr(hid_waddr), .acc_in(acc_in),
        .result(result), .batch_done(batch_done), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire any_out = |{sample_idx, feat_idx, w_addr, layer_sel, mac_clr, mac_en,
                     hid_we, hid_waddr, result, batch_done, done};

    int n_tests = 0;
    int n_fail  = 0;
    int bd_count = 0;

    typedef struct {
        int res;
        int at;
    } exp_t;
    exp_t exp_q[$];

    // Output-layer scores per sample and their hand-derived argmax.
    int tbl [NS*NO] = '{5, -3, 9, 9, 2,
                        4, 4, 4, 4, 4,
                        -7, -2, -9, -4, -8,
                        -1, 0, 3, -5, 7};
    int res_tbl [NS] = '{2, 0, 1, 4};

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_run(input int t0);
        exp_q.delete();
        bd_count = 0;
        for (int s = 0; s < NS; s++) begin
            exp_t e;
            e.res = res_tbl[s];
            e.at  = t0 + 1 + (s + 1) * CPS;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int t0, input string tag);
        int guard;
        guard = 0;
        while (!done && guard < NS * CPS + 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_level"}, int'(done), 1);
        check({tag, "_done_cycle"}, cyc, t0 + 1 + NS * CPS);
        check({tag, "_batch_count"}, bd_count, NS);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Datapath model: present the score belonging to the output row being addressed.
    initial begin
        int jj;
        forever begin
            @(negedge clk);
            acc_in = '0;
            if (layer_sel && int'(w_addr) >= BASE2) begin
                jj = (int'(w_addr) - BASE2) / W2;
                if (jj < NO && int'(sample_idx) < NS)
                    acc_in = AW'(tbl[int'(sample_idx) * NO + jj]);
            end
        end
    end

    // Monitor: pop and compare on every batch_done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && batch_done) begin
                bd_count++;
                if (exp_q.size() == 0) begin
                    check("batch_done_unexpected", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", int'(result), e.res);
                    check("batch_done_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        int t0;
        int cnt;
        int hw_cnt;
        int target;

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", int'(any_out), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt += int'(mac_en) + int'(mac_clr) + int'(hid_we);
        end
        check("idle_no_activity", cnt, 0);

        // Run A: start held high into L1_RUN must not restart the sequence.
        start = 1'b1;
        t0 = cyc;
        push_run(t0);
        hw_cnt = 0;
        for (int c = 1; c <= CPS; c++) begin
            @(negedge clk);
            if (c == 6) start = 1'b0;
            hw_cnt += int'(hid_we);
            if (c == 1) begin
                check("c1_mac_clr", int'(mac_clr), 1);
                check("c1_mac_en", int'(mac_en), 0);
                check("c1_w_addr", int'(w_addr), 0);
                check("c1_layer_sel", int'(layer_sel), 0);
            end
            if (c == 2) check("c2_mac_en_clr", int'({mac_en, mac_clr}), 2);
            if (c == 3) check("c3_no_reclear", int'(mac_clr), 0);
            if (c == W1) check("l1_row0_last_addr", int'(w_addr), W1 - 1);
            if (c == R1) check("l1_wb0", int'({hid_we, hid_waddr}), 256);
            if (c == R1 + 1) check("l1_row1_first_addr", int'(w_addr), W1);
            if (c == 2 * R1) check("l1_wb1", int'({hid_we, hid_waddr}), 257);
            if (c == NH * R1 + 1) begin
                check("l2_layer_sel", int'(layer_sel), 1);
                check("l2_first_addr", int'(w_addr), BASE2);
                check("l2_first_clr", int'(mac_clr), 1);
            end
            if (c == NH * R1 + (NO - 1) * R2 + W2)
                check("l2_last_addr", int'(w_addr), BASE2 + NO * W2 - 1);
        end
        check("hid_we_pulses", hw_cnt, NH);
        wait_done(t0, "runA");

        // Run B: restart from DONE, then reset during the last output write-back of sample 3.
        check("done_before_restart", int'(done), 1);
        start = 1'b1;
        t0 = cyc;
        push_run(t0);
        @(negedge clk);
        start = 1'b0;
        check("restart_done_cleared", int'(done), 0);
        check("restart_sample_idx", int'(sample_idx), 0);
        check("restart_mac_clr", int'(mac_clr), 1);
        target = t0 + 1 + 3 * CPS + NH * R1 + (NO - 1) * R2 + W2 + 1;
        while (cyc < target) @(negedge clk);
        check("prereset_in_l2_wb", int'({mac_en, layer_sel, mac_clr}), 2);
        check("prereset_sample", int'(sample_idx), 3);
        check("prereset_result", int'(result), 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_outputs_zero", int'(any_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Run C: fresh run after abort.
        start = 1'b1;
        t0 = cyc;
        push_run(t0);
        @(negedge clk);
        start = 1'b0;
        check("runC_sample_idx", int'(sample_idx), 0);
        check("runC_mac_clr", int'(mac_clr), 1);
        wait_done(t0, "runC");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
